fetch_pc_gen: RTL and testbench

- Fetch-request generator at the head of the front end. Emits a stream of instruction addresses on an AXI Stream manager port, which feeds the front-end skid buffer.
- Advances the PC by 4 on every accepted transfer.
- Applies redirects from the back end and produces the flush pulse that drives the downstream skid buffer's invalidate input.
- Limits in-flight requests with a credit counter.

---
 rtl/fetch_pc_gen_if.sv | 18 +
 rtl/fetch_pc_gen.sv | 167 ++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_if.sv
// ----------------------------------------------------------------------------
// axis_if: minimal AXI Stream channel used between the fetch PC generator
// and the front-end skid buffer.
//   tvalid  - manager -> subordinate, transfer valid
//   tdata   - manager -> subordinate, payload (instruction address)
//   tready  - subordinate -> manager, transfer accepted
// Modports: m (manager side), s (subordinate side).
// ----------------------------------------------------------------------------
interface axis_if #(
    parameter int TDATA_WIDTH = 32
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fetch_pc_gen.sv
// ----------------------------------------------------------------------------
// fetch_pc_gen: fetch-request generator at the head of the front end.
// Emits sequential instruction addresses on an AXI Stream manager port,
// applies back-end redirects (with a combinational flush pulse to the
// downstream skid buffer) and limits in-flight requests with a credit count.
//
// Ports:
//   clk            - clock
//   rst            - synchronous active-high reset
//   axis_mif       - request stream out (tvalid/tdata=PC out, tready in)
//   redirect_valid - single-cycle redirect request from the back end
//   redirect_pc    - redirect target (bits [1:0] forced to 0)
//   halt           - level; blocks new requests while high
//   credit_return  - one pulse per request fully consumed downstream
//   flush          - combinational copy of redirect_valid
//   outstanding    - current in-flight request count
//   misalign_err   - sticky error flag (only with FETCH_PC_GEN_MISALIGN_CHECK_EN)
//
// Optional feature macro: FETCH_PC_GEN_MISALIGN_CHECK_EN
//   Adds misalign_err, set on a misaligned redirect target or on a
//   credit_return while outstanding is 0; cleared only by rst.
//
// State  | meaning
// IDLE   | first cycle after reset, no request
// RUN    | issuing requests
// HALT   | halt high, no request until it drops
// ----------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 'h8000_0000,
    parameter int              MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    axis_if.m                                      axis_mif,
    input  logic                                   redirect_valid,
    input  logic [XLEN-1:0]                        redirect_pc,
    input  logic                                   halt,
    input  logic                                   credit_return,
    output logic                                   flush,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
`ifdef FETCH_PC_GEN_MISALIGN_CHECK_EN
    ,
    output logic                                   misalign_err
`endif
);

    localparam int            OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    if (XLEN != $bits(axis_mif.tdata)) begin : g_bad_width
        $fatal(1, "fetch_pc_gen: XLEN must equal axis_mif TDATA_WIDTH");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max
        $fatal(1, "fetch_pc_gen: MAX_OUTSTANDING must be 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_tvalid;
    logic            w_tvalid_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   w_out_next;
    logic            w_hs;
    logic            w_credit_ok;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_hs          = r_tvalid && axis_mif.tready;
    // A credit with nothing in flight is dropped so the counter never wraps.
    assign w_credit_ok   = credit_return && (r_outstanding != '0);
    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        w_out_next = r_outstanding;
        if (redirect_valid) begin
            w_out_next = '0;
        end else if (w_hs && !w_credit_ok) begin
            w_out_next = r_outstanding + OW'(1);
        end else if (!w_hs && w_credit_ok) begin
            w_out_next = r_outstanding - OW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = halt ? S_HALT : S_RUN;
            // Leave RUN only once nothing is pending on the bus; a redirect
            // discards the pending beat, so it also frees the way to HALT.
            S_RUN:   if (halt && (!r_tvalid || w_hs || redirect_valid))
                         w_state_next = S_HALT;
            S_HALT:  if (!halt) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid) begin
            w_pc_next = w_redirect_pc;
        end else if (w_hs) begin
            w_pc_next = r_pc + XLEN'(4);
        end
    end

    // tvalid depends only on registered state and side-band inputs through
    // w_hs, never combinationally on the output port.
    always_comb begin
        if (redirect_valid) begin
            w_tvalid_next = !halt;
        end else if (r_tvalid && !w_hs) begin
            w_tvalid_next = 1'b1;
        end else begin
            w_tvalid_next = (w_state_next == S_RUN) && !halt &&
                            (w_out_next < MAX_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tvalid      <= 1'b0;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_next;
            r_tvalid      <= w_tvalid_next;
            r_pc          <= w_pc_next;
            r_outstanding <= w_out_next;
        end
    end

`ifdef FETCH_PC_GEN_MISALIGN_CHECK_EN
    logic r_misalign_err;
    logic w_err_set;

    assign w_err_set = (redirect_valid && (redirect_pc[1:0] != 2'b00)) ||
                       (credit_return && !redirect_valid && (r_outstanding == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_err <= 1'b0;
        end else if (w_err_set) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`else
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^redirect_pc[1:0];
`endif

    assign axis_mif.tvalid = r_tvalid;
    assign axis_mif.tdata  = r_pc;
    assign outstanding     = r_outstanding;
    assign flush           = redirect_valid;

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        credit_return;
    logic        flush;
    logic [2:0]  outstanding;
`ifdef FETCH_PC_GEN_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int n_tests;
    int n_fail;

    axis_if #(.TDATA_WIDTH(32)) u_axis ();

    fetch_pc_gen #(
        .XLEN            (32),
        .RESET_PC        (32'h8000_0000),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .axis_mif       (u_axis),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .credit_return  (credit_return),
        .flush          (flush),
        .outstanding    (outstanding)
`ifdef FETCH_PC_GEN_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic v, input logic [31:0] d, input logic [2:0] o);
        check({tag, ".tvalid"}, {31'd0, u_axis.tvalid}, {31'd0, v});
        check({tag, ".tdata"}, u_axis.tdata, d);
        check({tag, ".outst"}, {29'd0, outstanding}, {29'd0, o});
    endtask

    logic [31:0] exp_seq [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_seq[0] = 32'h8000_0000;
        exp_seq[1] = 32'h8000_0004;
        exp_seq[2] = 32'h8000_0008;
        exp_seq[3] = 32'h8000_000C;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        credit_return  = 1'b0;
        u_axis.tready  = 1'b1;

        tick();
        // flush follows redirect_valid even in reset
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1234;
        #1;
        check("flush_in_reset", {31'd0, flush}, 32'd1);
        redirect_valid = 1'b0;
        tick();
        check_bus("reset", 1'b0, 32'h8000_0000, 3'd0);

        // Stream of four requests, then full
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_bus($sformatf("seq%0d", i), 1'b1, exp_seq[i], 3'(i));
            tick();
        end
        check_bus("full", 1'b0, 32'h8000_0010, 3'd4);
        tick();
        check_bus("full_hold", 1'b0, 32'h8000_0010, 3'd4);

        // One credit -> exactly one more request, one cycle later
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        check_bus("credit_req", 1'b1, 32'h8000_0010, 3'd3);
        tick();
        check_bus("credit_one", 1'b0, 32'h8000_0014, 3'd4);

        // Back-pressure: hold for 5 cycles
        u_axis.tready = 1'b0;
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_bus($sformatf("stall%0d", i), 1'b1, 32'h8000_0014, 3'd3);
            tick();
        end
        u_axis.tready = 1'b1;
        tick();
        u_axis.tready = 1'b0;
        check_bus("stall_rel", 1'b0, 32'h8000_0018, 3'd4);

        // Redirect together with hs and credit, outstanding 3
        credit_return = 1'b1;
        tick();
        check_bus("pre_redir", 1'b1, 32'h8000_0018, 3'd3);
        u_axis.tready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        #1;
        check("flush_redir", {31'd0, flush}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        credit_return  = 1'b0;
        u_axis.tready  = 1'b0;
        check_bus("redir", 1'b1, 32'h0000_1000, 3'd0);
        check("flush_low", {31'd0, flush}, 32'd0);

        // Halt while a beat is pending
        halt = 1'b1;
        tick();
        tick();
        check_bus("halt_hold", 1'b1, 32'h0000_1000, 3'd0);
        u_axis.tready = 1'b1;
        tick();
        check_bus("halt_hs", 1'b0, 32'h0000_1004, 3'd1);
        tick();
        check_bus("halted", 1'b0, 32'h0000_1004, 3'd1);
        halt = 1'b0;
        tick();
        u_axis.tready = 1'b0;
        check_bus("resume", 1'b1, 32'h0000_1004, 3'd1);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check_bus("wrap_pre", 1'b1, 32'hFFFF_FFFC, 3'd0);
        u_axis.tready = 1'b1;
        tick();
        u_axis.tready = 1'b0;
        check_bus("wrap", 1'b1, 32'h0000_0000, 3'd1);

        // Credit down to 0, then an underflowing credit
        credit_return = 1'b1;
        tick();
        check_bus("credit0", 1'b1, 32'h0000_0000, 3'd0);
`ifdef FETCH_PC_GEN_MISALIGN_CHECK_EN
        check("err_clear", {31'd0, misalign_err}, 32'd0);
`endif
        tick();
        credit_return = 1'b0;
        check_bus("underflow", 1'b1, 32'h0000_0000, 3'd0);
`ifdef FETCH_PC_GEN_MISALIGN_CHECK_EN
        check("err_underflow", {31'd0, misalign_err}, 32'd1);
`endif

        // Reset again, then misaligned redirect straight out of IDLE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bus("reset2", 1'b0, 32'h8000_0000, 3'd0);
`ifdef FETCH_PC_GEN_MISALIGN_CHECK_EN
        check("err_rst", {31'd0, misalign_err}, 32'd0);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        tick();
        redirect_valid = 1'b0;
        check_bus("misalign", 1'b1, 32'h0000_1000, 3'd0);
`ifdef FETCH_PC_GEN_MISALIGN_CHECK_EN
        check("err_misalign", {31'd0, misalign_err}, 32'd1);
        tick();
        check("err_sticky", {31'd0, misalign_err}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
